// File: rtl/mult4_seq_ctrl.sv
// Sequencing wrapper around the combinational mult4 array multiplier.
// Accepts operand pairs, holds them for a settle time, then registers the product and a running accumulator.
module mult4_seq_ctrl #(
  parameter int ACC_W         = 12,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [1:0]       in_op,
  output logic [3:0]       mult_a,
  output logic [3:0]       mult_b,
  input  logic [7:0]       mult_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_p,
  output logic [ACC_W-1:0] out_acc,
  output logic             acc_ovf
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] OP_MAC = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       op_reg;
  logic [3:0]       mult_a_reg;
  logic [3:0]       mult_b_reg;
  logic [7:0]       out_p_reg;
  logic [ACC_W-1:0] out_acc_reg;
  logic             acc_ovf_reg;
  logic             out_valid_reg;

  logic             accept;
  logic             capture;
  logic [ACC_W:0]   mac_sum;

  assign accept  = in_valid & in_ready;
  // The product is sampled on the edge that would take the counter to zero.
  assign capture = (state_reg == SETTLE) && (cnt_reg == CNT_W'(1));
  assign mac_sum = {1'b0, out_acc_reg} + (ACC_W + 1)'(mult_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = SETTLE;
      SETTLE:  if (capture)   state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = rst_n && (state_reg == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      op_reg        <= '0;
      mult_a_reg    <= '0;
      mult_b_reg    <= '0;
      out_p_reg     <= '0;
      out_acc_reg   <= '0;
      acc_ovf_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        mult_a_reg <= in_a;
        mult_b_reg <= in_b;
        op_reg     <= in_op;
        cnt_reg    <= CNT_W'(SETTLE_CYCLES);
      end else if (state_reg == SETTLE) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end

      if (capture) begin
        out_valid_reg <= 1'b1;
        case (op_reg)
          OP_CLR: begin
            out_p_reg   <= '0;
            out_acc_reg <= '0;
            acc_ovf_reg <= 1'b0;
          end
          OP_MAC: begin
            out_p_reg   <= mult_p;
            out_acc_reg <= mac_sum[ACC_W-1:0];
            if (mac_sum[ACC_W]) acc_ovf_reg <= 1'b1;
          end
          // MUL and the reserved encoding only refresh the product.
          default: out_p_reg <= mult_p;
        endcase
      end else if ((state_reg == HOLD) && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign mult_a    = mult_a_reg;
  assign mult_b    = mult_b_reg;
  assign out_p     = out_p_reg;
  assign out_acc   = out_acc_reg;
  assign acc_ovf   = acc_ovf_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Self-checking bench for mult4_seq_ctrl: vector table, directed corner cases and random ops against an arithmetic model.
module tb_mult4_seq_ctrl;

  localparam int ACC_W  = 12;
  localparam int SETTLE = 1;
  localparam int ACC_M  = 1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic [1:0]       in_op;
  logic [3:0]       mult_a;
  logic [3:0]       mult_b;
  logic [7:0]       mult_p;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_p;
  logic [ACC_W-1:0] out_acc;
  logic             acc_ovf;

  int checks   = 0;
  int failures = 0;

  // Reference model state: plain integers following the operation rules.
  int m_p   = 0;
  int m_acc = 0;
  int m_ovf = 0;

  int obs_p, obs_acc, obs_ovf;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    int         p;
    int         acc;
    int         ovf;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational mult4 array.
  assign mult_p = 8'(mult_a * mult_b);

  mult4_seq_ctrl #(.ACC_W(ACC_W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_p    (mult_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_acc   (out_acc),
    .acc_ovf   (acc_ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_op(input int a, input int b, input int op);
    int s;
    if (op == 2) begin
      m_p = 0; m_acc = 0; m_ovf = 0;
    end else if (op == 1) begin
      m_p = a * b;
      s = m_acc + m_p;
      if (s >= ACC_M) m_ovf = 1;
      m_acc = s % ACC_M;
    end else begin
      m_p = a * b;
    end
  endtask

  // One complete transaction; inputs are scrambled after the accept edge.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, input int delay);
    int wt;
    int lat;
    wt = 0;
    while (!in_ready && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    chk("in_ready_idle", int'(in_ready), 1);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    out_ready = (delay == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 4'($urandom); in_b = 4'($urandom); in_op = 2'($urandom);
    model_op(int'(a), int'(b), int'(op));
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, SETTLE);
    chk("out_p", int'(out_p), m_p);
    chk("out_acc", int'(out_acc), m_acc);
    chk("acc_ovf", int'(acc_ovf), m_ovf);
    chk("mult_a_held", int'(mult_a), int'(a));
    chk("mult_b_held", int'(mult_b), int'(b));
    chk("in_ready_busy", int'(in_ready), 0);
    obs_p = int'(out_p); obs_acc = int'(out_acc); obs_ovf = int'(acc_ovf);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_p", int'(out_p), m_p);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("valid_drop", int'(out_valid), 0);
    chk("in_ready_back", int'(in_ready), 1);
    $display("op=%0d a=%0d b=%0d delay=%0d -> p=0x%0h acc=0x%0h ovf=%0d", op, a, b, delay, obs_p, obs_acc, obs_ovf);
    out_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{a: 4'd15, b: 4'd15, op: 2'b00, p: 'hE1, acc: 'h000, ovf: 0};
    tbl[1] = '{a: 4'd3,  b: 4'd5,  op: 2'b01, p: 'h0F, acc: 'h00F, ovf: 0};
    tbl[2] = '{a: 4'd2,  b: 4'd2,  op: 2'b01, p: 'h04, acc: 'h013, ovf: 0};
    tbl[3] = '{a: 4'd7,  b: 4'd9,  op: 2'b11, p: 'h3F, acc: 'h013, ovf: 0};
    tbl[4] = '{a: 4'd0,  b: 4'd9,  op: 2'b01, p: 'h00, acc: 'h013, ovf: 0};
    tbl[5] = '{a: 4'd5,  b: 4'd5,  op: 2'b10, p: 'h00, acc: 'h000, ovf: 0};
    tbl[6] = '{a: 4'd12, b: 4'd10, op: 2'b01, p: 'h78, acc: 'h078, ovf: 0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    #3;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_p", int'(out_p), 0);
    chk("rst_out_acc", int'(out_acc), 0);
    chk("rst_acc_ovf", int'(acc_ovf), 0);
    chk("rst_mult_a", int'(mult_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].op, i % 2);
      chk("tbl_p", obs_p, tbl[i].p);
      chk("tbl_acc", obs_acc, tbl[i].acc);
      chk("tbl_ovf", obs_ovf, tbl[i].ovf);
    end

    // Accumulator wrap at ACC_W=12
    do_op(4'd1, 4'd1, 2'b10, 0);
    for (int i = 0; i < 18; i++) do_op(4'd15, 4'd15, 2'b01, 0);
    chk("mac18_acc", obs_acc, 'hFD2);
    chk("mac18_ovf", obs_ovf, 0);
    do_op(4'd15, 4'd15, 2'b01, 0);
    chk("wrap_acc", obs_acc, 'h0B3);
    chk("wrap_ovf", obs_ovf, 1);
    do_op(4'd3, 4'd3, 2'b00, 0);
    chk("ovf_sticky", obs_ovf, 1);
    do_op(4'd9, 4'd9, 2'b10, 0);
    chk("clr_acc", obs_acc, 0);
    chk("clr_ovf", obs_ovf, 0);
    chk("clr_p", obs_p, 0);

    // Backpressure
    do_op(4'd3, 4'd5, 2'b00, 4);
    chk("bp_p", obs_p, 'h0F);

    // Random operations against the model
    for (int i = 0; i < 60; i++) begin
      do_op(4'($urandom), 4'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset during SETTLE of a MAC
    do_op(4'd6, 4'd7, 2'b01, 0);
    in_a = 4'd8; in_b = 4'd8; in_op = 2'b01; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_abort_busy", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    m_p = 0; m_acc = 0; m_ovf = 0;
    chk("abort_out_acc", int'(out_acc), 0);
    chk("abort_out_p", int'(out_p), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_mult_a", int'(mult_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", int'(in_ready), 1);
    repeat (3) @(negedge clk);
    chk("abort_no_valid", int'(out_valid), 0);
    chk("abort_no_acc", int'(out_acc), 0);
    do_op(4'd2, 4'd3, 2'b01, 1);
    chk("post_abort_acc", obs_acc, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
